// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
//   IDX_W()              : index width for an N-entry requester set (clog2, min 1)
//   DEFAULT_NUM_REQ      : default requester count
//   DEFAULT_DATA_WIDTH   : default FIFO data width
//   DEFAULT_CNT_WIDTH    : default grant-counter width
//   CNT_SAT_MAX          : all-ones pattern, sliced to the counter width for saturation
package fifo_arb_pkg;

  localparam int unsigned DEFAULT_NUM_REQ    = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;
  localparam logic [63:0] CNT_SAT_MAX        = '1;

  function automatic int unsigned IDX_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker (pure combinational).
// Scans i_req starting at i_ptr, wrapping modulo NUM_REQ, and returns the first set bit.
//   i_req   : request vector
//   i_ptr   : highest-priority position for this cycle
//   o_grant : one-hot winner (0 when no request)
//   o_idx   : binary winner index (0 when no request)
//   o_valid : at least one request present
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned IW     = IDX_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int unsigned w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pos = (32'(i_ptr) + i) % NUM_REQ;
      // First hit in scan order wins; later hits are ignored.
      if (!o_valid && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NUM_REQ producers.
// Grant is combinational from registered pointer state; no write while i_fifo_full=1.
// Optional feature macro: FIFO_WR_ARBITER_STATS_EN adds per-requester saturating grant
// counters (o_grant_cnt) with a synchronous clear (i_stats_clr).
//   i_clk          : clock, rising edge
//   i_rst          : asynchronous active-low reset; also forces grant/write outputs to 0
//   i_req          : per-producer request, held until granted
//   i_req_data     : packed producer data, slice k = [k*DATA_WIDTH +: DATA_WIDTH]
//   o_grant        : one-hot; req_data[k] is written at this edge
//   i_fifo_full    : FIFO full flag
//   o_fifo_w_en    : FIFO write enable
//   o_fifo_data_in : FIFO write data
//   o_last_idx     : registered index of the most recent winner
//   o_busy         : registered; a write happened in the previous cycle
//   o_grant_cnt    : (stats) packed counters, slice k = [k*CNT_WIDTH +: CNT_WIDTH]
//   i_stats_clr    : (stats) synchronous clear of all counters, wins over increment
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_grant,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_w_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
  output logic [IDX_W(NUM_REQ)-1:0]     o_last_idx,
  output logic                          o_busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  o_grant_cnt,
  input  logic                          i_stats_clr
`endif
);

  localparam int unsigned IW = IDX_W(NUM_REQ);

  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_last_idx;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_write;
  logic [IW-1:0]      w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Reset level is part of the write qualifier so an in-flight grant drops immediately.
  assign w_write    = i_rst && !i_fifo_full && w_pick_valid;
  assign w_next_ptr = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + IW'(1);

  always_comb begin
    o_grant        = '0;
    o_fifo_w_en    = 1'b0;
    o_fifo_data_in = '0;
    if (w_write) begin
      o_grant        = w_pick_grant;
      o_fifo_w_en    = 1'b1;
      o_fifo_data_in = i_req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr_ptr   <= '0;
      r_last_idx <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= w_write;
      if (w_write) begin
        r_rr_ptr   <= w_next_ptr;
        r_last_idx <= w_pick_idx;
      end
    end
  end

  assign o_last_idx = r_last_idx;
  assign o_busy     = r_busy;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt [NUM_REQ];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (i_stats_clr) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (o_grant[k] && (r_cnt[k] != CNT_SAT_MAX[CNT_WIDTH-1:0])) begin
          r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_grant_cnt[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port (w_en/data_in/full) between NUM_REQ producers.
- Sits directly in front of the fifo instance. Each producer uses a req/grant handshake; the arbiter drives the FIFO write port and never writes while the FIFO reports full.
- The grant decision is combinational from registered round-robin state, so back-to-back writes are safe against the FIFO's own full flag.

Parameters:
NUM_REQ, 4, number of requesting producers (2..16)
DATA_WIDTH, 8, FIFO data width; must match the fifo data_width
CNT_WIDTH, 16, width of per-requester grant counters (optional feature only)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-producer write request; held high until granted
req_data  input  NUM_REQ*DATA_WIDTH  packed producer data; slice k = [k*DATA_WIDTH +: DATA_WIDTH]; held stable while req[k]=1
grant  output  NUM_REQ  one-hot; grant[k]=1 means req_data[k] is written at this rising edge
fifo_full  input  1  full flag from the fifo
fifo_w_en  output  1  to fifo w_en
fifo_data_in  output  DATA_WIDTH  to fifo data_in
last_idx  output  $clog2(NUM_REQ)  registered index of the most recent winner
busy  output  1  registered; 1 if a write happened in the previous cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, last_idx=0, busy=0, counters=0.
  - grant, fifo_w_en and fifo_data_in are forced to 0 while rst=0, regardless of req.
- Arbitration (combinational each cycle):
  - If fifo_full=1 or req=0: grant=0, fifo_w_en=0, fifo_data_in=0.
  - Otherwise the winner k is the first set req bit scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - Then grant=one-hot(k), fifo_w_en=1, fifo_data_in=req_data slice k.
- Sequential update, rising edge with fifo_w_en=1: rr_ptr<=(k+1) mod NUM_REQ, last_idx<=k, busy<=1.
- Sequential update, no write: rr_ptr and last_idx hold, busy<=0.
- Handshake:
  - A producer's transfer completes on the edge where req[k]&grant[k]=1.
  - The producer may drop req or present new data in the following cycle.
  - The arbiter keeps no data buffer.
- Throughput: 1 write per cycle while not full. Zero latency from req to grant.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Full boundary:
  - The fifo_full rising edge blocks the grant in that same cycle, so no write is attempted into a full FIFO.
  - Pending requests are preserved and the pointer does not move.
- Wrap-around: the pointer wraps from NUM_REQ-1 to 0. When only one requester is active it wins every cycle.
- Reset mid-operation: an in-flight grant is dropped immediately (combinational force). After release, arbitration restarts from requester 0.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*CNT_WIDTH).
  - Adds input stats_clr (1 bit, synchronous clear of all counters).
  - Counter k increments on each edge with grant[k]=1 and saturates at all-ones.
  - stats_clr has priority over increment.
- When undefined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - IDX_W function (clog2 helper)
  - default DATA_WIDTH and NUM_REQ constants
  - the grant-counter saturation constant.
- One sub-module is natural: rr_pick (pure combinational). Inputs req and ptr; outputs one-hot grant, index and any-valid. It is reusable for a read-side scheduler.

Test Plan:
- Reset, then req=4'b1111 continuously with fifo_full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; FIFO receives the slices in that order; busy=1 from cycle 2.
- rr_ptr=2 (after granting 1), req=4'b0011 -> grant=4'b0001 (index 0, wrap), then 4'b0010.
- Only req[2]=1 with data 8'hA5 for 5 cycles -> grant[2] every cycle; 5 writes of A5; last_idx=2.
- fifo_full=1 with req=4'b1010 -> grant=0, fifo_w_en=0, ptr unchanged. Deassert full -> grant[1] first, then grant[3].
- Assert rst low mid-burst while grant[3]=1 -> grant/fifo_w_en drop immediately. After release with req=4'b1111 -> first grant is index 0.
- With FIFO_WR_ARBITER_STATS_EN and CNT_WIDTH=2: 5 grants to requester 1 -> grant_cnt[1]=3 (saturated). Pulse stats_clr -> 0.
